// File: rtl/risp_neuron.sv
// -----------------------------------------------------------------------------
// risp_neuron
//   Integrate-and-fire neuron stage. Each enabled cycle, all signed synapse
//   charges are summed into the membrane potential. The potential is either
//   retained or leaked (cleared) first. The new value is clamped at a floor and
//   compared against a firing threshold. A crossing resets the potential to 0
//   and produces a one-cycle fire pulse for the outgoing synapses. A saturating
//   spike counter is kept for host readout.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   arstn      : asynchronous active-low reset
//   en         : timestep enable; when low, potential/fire/count hold
//   inp        : NUM_INP packed signed charges, slice i = inp[i*CW +: CW]
//   cnt_clr    : synchronous clear of fire_count (works regardless of en)
//   fire       : spike pulse (registered, or same-cycle when FIRE_LIKE_RAVENS)
//   potential  : registered signed membrane potential
//   fire_count : saturating count of fires since reset/clear
// -----------------------------------------------------------------------------
module risp_neuron #(
  parameter int          NUM_INP          = 1,
  parameter int          CHARGE_WIDTH     = 8,
  parameter int signed   THRESHOLD        = 1,
  parameter int signed   MIN_POTENTIAL    = -128,
  parameter bit          LEAK             = 1'b0,
  parameter int          COUNT_WIDTH      = 16,
  parameter bit          FIRE_LIKE_RAVENS = 1'b0
) (
  input  logic                              clk,
  input  logic                              arstn,
  input  logic                              en,
  input  logic [NUM_INP*CHARGE_WIDTH-1:0]   inp,
  input  logic                              cnt_clr,
  output logic                              fire,
  output logic signed [CHARGE_WIDTH-1:0]    potential,
  output logic [COUNT_WIDTH-1:0]            fire_count
);

  // The potential plus NUM_INP charges are NUM_INP+1 terms, so this width
  // cannot overflow while accumulating.
  localparam int SUM_W = CHARGE_WIDTH + $clog2(NUM_INP + 1) + 1;

  localparam logic signed [SUM_W-1:0]        THR_EXT = SUM_W'(THRESHOLD);
  localparam logic signed [SUM_W-1:0]        MIN_EXT = SUM_W'(MIN_POTENTIAL);
  localparam logic signed [CHARGE_WIDTH-1:0] MIN_CW  = CHARGE_WIDTH'(MIN_POTENTIAL);

  logic signed [CHARGE_WIDTH-1:0] r_potential;
  logic                           r_fire;
  logic [COUNT_WIDTH-1:0]         r_count;

  logic signed [SUM_W-1:0]        w_next;
  logic                           w_crossing;
  logic signed [CHARGE_WIDTH-1:0] w_new_pot;

  // Evaluation of the current timestep.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default first, so the accumulation reads in order and no latch is inferred.
    w_next = LEAK ? '0 : SUM_W'(r_potential);
    for (int i = 0; i < NUM_INP; i++) begin
      w_next = w_next + SUM_W'($signed(inp[i*CHARGE_WIDTH +: CHARGE_WIDTH]));
    end

    w_crossing = (w_next >= THR_EXT);

    // Below the threshold the sum already fits CHARGE_WIDTH, so the
    // truncation in the last branch drops only sign-extension bits.
    if (w_crossing) begin
      w_new_pot = '0;
    end else if (w_next < MIN_EXT) begin
      w_new_pot = MIN_CW;
    end else begin
      w_new_pot = w_next[CHARGE_WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values; only the small state registers exist here, all reset.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_potential <= '0;
      r_fire      <= 1'b0;
      r_count     <= '0;
    end else begin
      if (en) begin
        r_potential <= w_new_pot;
        r_fire      <= w_crossing;
      end
      // Clear takes priority over a simultaneous increment.
      if (cnt_clr) begin
        r_count <= '0;
      end else if (en && w_crossing && !(&r_count)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Same-cycle mode gates with arstn so fire stays low throughout reset.
  assign fire       = FIRE_LIKE_RAVENS ? (w_crossing & en & arstn) : r_fire;
  assign potential  = r_potential;
  assign fire_count = r_count;

endmodule

// File: tb/tb_risp_neuron.sv
// -----------------------------------------------------------------------------
// tb_risp_neuron
//   Three neuron instances share clock, reset and stimulus but differ in
//   configuration:
//     0: THRESHOLD=5, retain, registered fire, 16-bit counter
//     1: THRESHOLD=5, full leak, same-cycle fire, 16-bit counter
//     2: THRESHOLD=1, retain, registered fire, 2-bit counter
//   A behavioural model keeps the potential, last crossing and count of each
//   instance as plain integers. Directed steps come first, then random steps.
// -----------------------------------------------------------------------------
module tb_risp_neuron;

  localparam int CW = 8;
  localparam int N  = 3;

  localparam int THR  [N] = '{5, 5, 1};
  localparam bit LK   [N] = '{1'b0, 1'b1, 1'b0};
  localparam bit RAV  [N] = '{1'b0, 1'b1, 1'b0};
  localparam int CMAX [N] = '{65535, 65535, 3};
  localparam int MINP = -128;

  logic              clk = 1'b0;
  logic              arstn = 1'b0;
  logic              en = 1'b0;
  logic              cnt_clr = 1'b0;
  logic [2*CW-1:0]   inp = '0;

  logic              fire_0, fire_1, fire_2;
  logic signed [CW-1:0] pot_0, pot_1, pot_2;
  logic [15:0]       cnt_0, cnt_1;
  logic [1:0]        cnt_2;

  int n_cmp = 0;
  int n_mis = 0;

  // Model state and the currently applied stimulus.
  int m_pot [N];
  bit m_fr  [N];
  int m_cnt [N];
  int cur_a = 0, cur_b = 0;

  always #5 clk = ~clk;

  risp_neuron #(.NUM_INP(2), .CHARGE_WIDTH(CW), .THRESHOLD(5), .MIN_POTENTIAL(-128),
                .LEAK(1'b0), .COUNT_WIDTH(16), .FIRE_LIKE_RAVENS(1'b0)) u_n0 (
    .clk(clk), .arstn(arstn), .en(en), .inp(inp), .cnt_clr(cnt_clr),
    .fire(fire_0), .potential(pot_0), .fire_count(cnt_0));

  risp_neuron #(.NUM_INP(2), .CHARGE_WIDTH(CW), .THRESHOLD(5), .MIN_POTENTIAL(-128),
                .LEAK(1'b1), .COUNT_WIDTH(16), .FIRE_LIKE_RAVENS(1'b1)) u_n1 (
    .clk(clk), .arstn(arstn), .en(en), .inp(inp), .cnt_clr(cnt_clr),
    .fire(fire_1), .potential(pot_1), .fire_count(cnt_1));

  risp_neuron #(.NUM_INP(2), .CHARGE_WIDTH(CW), .THRESHOLD(1), .MIN_POTENTIAL(-128),
                .LEAK(1'b0), .COUNT_WIDTH(2), .FIRE_LIKE_RAVENS(1'b0)) u_n2 (
    .clk(clk), .arstn(arstn), .en(en), .inp(inp), .cnt_clr(cnt_clr),
    .fire(fire_2), .potential(pot_2), .fire_count(cnt_2));

  task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_next(int k);
    return (LK[k] ? 0 : m_pot[k]) + cur_a + cur_b;
  endfunction

  function automatic bit model_fire(int k);
    if (RAV[k]) return (model_next(k) >= THR[k]) && en && arstn;
    return m_fr[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_pot[k] = 0; m_fr[k] = 1'b0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_edge(bit e, bit c);
    for (int k = 0; k < N; k++) begin
      int nx;
      bit cr;
      nx = model_next(k);
      cr = (nx >= THR[k]);
      if (e) begin
        m_pot[k] = cr ? 0 : ((nx < MINP) ? MINP : nx);
        m_fr[k]  = cr;
      end
      if (c) m_cnt[k] = 0;
      else if (e && cr && m_cnt[k] < CMAX[k]) m_cnt[k]++;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check_inst(string tag, int k, logic f, logic signed [CW-1:0] p, logic [15:0] c);
    check($sformatf("%s.n%0d.fire", tag, k), {31'b0, f}, {31'b0, model_fire(k)});
    check($sformatf("%s.n%0d.potential", tag, k), p, m_pot[k]);
    check($sformatf("%s.n%0d.fire_count", tag, k), c, m_cnt[k]);
  endtask

  task automatic check_all(string tag);
    check_inst(tag, 0, fire_0, pot_0, cnt_0);
    check_inst(tag, 1, fire_1, pot_1, cnt_1);
    check_inst(tag, 2, fire_2, pot_2, {14'b0, cnt_2});
  endtask

  // One timestep: apply inputs, check before the edge, advance model at the edge.
  // Entered and left at 1 time unit after a rising edge.
  task automatic step(string tag, int a, int b, bit e, bit c);
    cur_a = a; cur_b = b;
    inp = {CW'(b), CW'(a)};
    en = e; cnt_clr = c;
    #2;
    check_all(tag);
    @(posedge clk);
    model_edge(e, c);
    #1;
  endtask

  // Reset pulse between edges; outputs must clear without a clock edge.
  task automatic do_reset(string tag, int a, int b);
    cur_a = a; cur_b = b;
    inp = {CW'(b), CW'(a)};
    en = 1'b1; cnt_clr = 1'b0;
    #1;
    arstn = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    en = 1'b0;
    #1;
    arstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check_all("por");
    arstn = 1'b1;
    @(posedge clk);
    #1;

    // 1: two enabled cycles of (2,1) on instance 0 -> 3, then 6 fires.
    step("t1a", 2, 1, 1'b1, 1'b0);
    check("t1.pot_after_first", pot_0, 3);
    step("t1b", 2, 1, 1'b1, 1'b0);
    check("t1.fire", {31'b0, fire_0}, 1);
    check("t1.pot_after_fire", pot_0, 0);
    check("t1.count", cnt_0, 1);
    step("t1c", 0, 0, 1'b1, 1'b0);
    check("t1.fire_one_cycle", {31'b0, fire_0}, 0);

    // 2: floor clamp without wrap, then a large positive crossing.
    step("t2a", -100, -100, 1'b1, 1'b0);
    check("t2.clamp", pot_0, -128);
    step("t2b", 127, 127, 1'b1, 1'b0);
    check("t2.pot_after_fire", pot_0, 0);
    check("t2.fire", {31'b0, fire_0}, 1);

    // 3: leaking instance 1 never accumulates (3,0), fires on (3,3).
    step("t3a", 3, 0, 1'b1, 1'b0);
    step("t3b", 3, 0, 1'b1, 1'b0);
    step("t3c", 3, 0, 1'b1, 1'b0);
    check("t3.leak_pot", pot_1, 3);
    step("t3d", 3, 3, 1'b1, 1'b0);
    check("t3.pot_after_fire", pot_1, 0);

    // 4: same-cycle fire, then en=0 with the same inputs.
    cur_a = 5; cur_b = 0;
    inp = {CW'(0), CW'(5)}; en = 1'b1;
    #1;
    check("t4.comb_fire", {31'b0, fire_1}, 1);
    en = 1'b0;
    #1;
    check("t4.fire_gated", {31'b0, fire_1}, 0);
    step("t4b", 5, 0, 1'b0, 1'b0);
    check("t4.pot_hold", pot_1, 0);
    check("t4.pot_hold_n0", pot_0, m_pot[0]);

    // 5: 2-bit counter saturates at 3; clear wins over a 6th fire.
    do_reset("t5rst", 0, 0);
    step("t5a", 1, 0, 1'b1, 1'b0);
    check("t5.cnt1", {30'b0, cnt_2}, 1);
    step("t5b", 1, 0, 1'b1, 1'b0);
    check("t5.cnt2", {30'b0, cnt_2}, 2);
    step("t5c", 1, 0, 1'b1, 1'b0);
    check("t5.cnt3", {30'b0, cnt_2}, 3);
    step("t5d", 1, 0, 1'b1, 1'b0);
    step("t5e", 1, 0, 1'b1, 1'b0);
    check("t5.sat", {30'b0, cnt_2}, 3);
    step("t5f", 1, 0, 1'b1, 1'b1);
    check("t5.clr_wins", {30'b0, cnt_2}, 0);

    // 6: reset mid-accumulation, then restart from 0.
    do_reset("t6rst0", 0, 0);
    step("t6a", 2, 2, 1'b1, 1'b0);
    check("t6.pot4", pot_0, 4);
    do_reset("t6rst", 5, 0);
    step("t6b", 1, 0, 1'b1, 1'b0);
    check("t6.restart", pot_0, 1);

    // Random timesteps with occasional disable, clear and reset.
    for (int s = 0; s < 400; s++) begin
      int a, b;
      bit e, c;
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 3) == 0) b = int'($urandom_range(0, 8)) - 4;
      e = ($urandom_range(0, 4) != 0);
      c = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst", a, b);
      else step("rnd", a, b, e, c);
    end
    step("final", 0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/risp_neuron.md
Name: risp_neuron

Overview:
Integrate-and-fire neuron stage that consumes the signed weighted charges produced by its incoming RISP synapses. Each enabled cycle it sums all synaptic charges into a membrane potential, applies leak and floor rules, and compares against a threshold. On a threshold crossing it emits a one-cycle fire pulse, which drives the input of every outgoing synapse. It also keeps a saturating spike counter for host readout.

Parameters:
NUM_INP, 1, number of incoming synapse charge ports (>=1)
CHARGE_WIDTH, 8, signed width of each synapse charge, of the potential and of the threshold
THRESHOLD, 1, signed firing threshold; fire when potential >= THRESHOLD
MIN_POTENTIAL, -128, signed floor for the potential; must fit in CHARGE_WIDTH
LEAK, 0, 1 = potential fully leaks (cleared) every enabled cycle it does not persist; 0 = potential retained
COUNT_WIDTH, 16, width of the spike counter
FIRE_LIKE_RAVENS, 0, 0 = fire output registered; 1 = fire output combinational from the current-cycle evaluation

Ports:
clk  input  1  clock; all state updates on rising edge
arstn  input  1  asynchronous active-low reset
en  input  1  timestep enable; when 0 all state holds
inp  input  NUM_INP*CHARGE_WIDTH  packed signed charges; slice i = inp[i*CHARGE_WIDTH +: CHARGE_WIDTH]
cnt_clr  input  1  synchronous clear of fire_count (independent of en)
fire  output  1  spike pulse to downstream synapses
potential  output  CHARGE_WIDTH  signed current membrane potential (registered)
fire_count  output  COUNT_WIDTH  number of fires since reset/clear, saturating

Behaviour:
- Reset (arstn=0, async): potential=0, fire register=0, fire_count=0. With FIRE_LIKE_RAVENS=1, fire is 0 while reset is asserted.
- Internal sum width: CHARGE_WIDTH + clog2(NUM_INP+1) + 1 bits, signed; no intermediate overflow.
- base = LEAK ? 0 : potential.
- next = base + sum over i of inp slice i, all sign-extended.
- Evaluation, combinational each cycle:
  - crossing = (next >= THRESHOLD).
  - If crossing: new_pot = 0.
  - Else if next < MIN_POTENTIAL: new_pot = MIN_POTENTIAL.
  - Else: new_pot = next. next is then necessarily below THRESHOLD, so it fits in CHARGE_WIDTH.
- On a clock edge with en=1:
  - potential <= new_pot.
  - Fire register <= crossing.
  - If crossing and fire_count not all-ones: fire_count increments.
- On a clock edge with en=0: potential, fire register and fire_count hold (cnt_clr still applies). No pulse is generated.
- cnt_clr=1: fire_count <= 0 on that edge. Clear wins over a simultaneous increment.
- Output timing:
  - FIRE_LIKE_RAVENS=0: fire = fire register. The pulse appears the cycle after the crossing edge and lasts exactly one enabled cycle. If the next cycle has en=0, the pulse holds until the following enabled edge.
  - FIRE_LIKE_RAVENS=1: fire = crossing & en, same cycle (zero latency). Upstream synapses are then built with one less delay stage.
- Counter saturation: at 2^COUNT_WIDTH-1 it stays there on further fires.
- Firing every consecutive cycle is allowed; potential is 0 after each fire.
- The potential output always shows the registered value, never next.

Test Plan:
1. NUM_INP=2, THRESHOLD=5, LEAK=0, FIRE_LIKE_RAVENS=0: inp=(2,1) for 2 enabled cycles -> potential 3 then 6≥5. The second edge sets the fire register, so fire=1 for one cycle; potential=0 and fire_count=1.
2. Same config, inp=(-100,-100) for 1 cycle, MIN_POTENTIAL=-128 -> potential=-128 (clamped, no wrap). Then inp=(127,127) -> next=126≥5, so fire and potential=0.
3. LEAK=1, THRESHOLD=5: inp=(3,0) for 3 cycles -> potential stays 3, no fire. Then inp=(3,3) -> fire, potential=0.
4. Same-cycle fire, FIRE_LIKE_RAVENS=1: inp=(5,0) with en=1 -> fire=1 combinationally in that cycle. Drop en=0 with the same inp -> fire=0 and potential holds.
5. COUNT_WIDTH=2, THRESHOLD=1, inp=(1,0) continuously for 5 enabled cycles -> fire_count 1,2,3,3,3. Asserting cnt_clr on the cycle of a 6th fire -> fire_count=0.
6. Assert arstn=0 mid-accumulation (potential=4) between clock edges -> potential, fire and fire_count go to 0 immediately. After release, the first enabled edge restarts from 0.
